fir_coef_loader: RTL and testbench

Front-end sequencer that sits directly upstream of the resource-shared FIR filter. It holds a programmable bank of filter coefficients and, on command, streams them into the filter's coefficient port using the `writeen`/`tlast` protocol. Once the stream is complete it opens a gated sample path so that `x_out` feeds the filter's `x_in` only after the coefficients are fully loaded.

---
 rtl/fir_coef_loader.sv | 87 ++++++++
 tb/tb_fir_coef_loader.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coef_loader.sv
// Coefficient bank and load sequencer for the shared FIR filter.
// Streams the bank on writeen/tlast, then opens the zero-gated sample path.
module fir_coef_loader #(
    parameter int NTAPS = 7,
    parameter int CW    = 8,
    parameter int DW    = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [CW-1:0] cfg_data,
    input  logic          load_start,
    input  logic [DW-1:0] x_src,
    input  logic          x_src_valid,
    output logic [CW-1:0] coef_val,
    output logic          writeen,
    output logic          tlast,
    output logic [DW-1:0] x_out,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NTAPS - 1);
    localparam logic [AW:0]   NTAPS_W  = (AW + 1)'(NTAPS);

    state_t        state;
    logic [AW-1:0] idx;
    logic [CW-1:0] bank [NTAPS];
    logic          bank_we;

    // Bank is frozen while streaming so a load always sends a consistent set.
    assign bank_we = cfg_we && ({1'b0, cfg_addr} < NTAPS_W) && (state != LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NTAPS; i++) begin
                bank[i] <= '0;
            end
        end else if (bank_we) begin
            bank[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            coef_val <= '0;
            writeen  <= 1'b0;
            tlast    <= 1'b0;
            x_out    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            writeen <= 1'b0;
            tlast   <= 1'b0;
            done    <= tlast;
            busy    <= (state == LOAD);
            x_out   <= (state == RUN && x_src_valid) ? x_src : '0;

            unique case (state)
                IDLE, RUN: begin
                    if (load_start) begin
                        state <= LOAD;
                        idx   <= '0;
                    end
                end
                LOAD: begin
                    coef_val <= bank[idx];
                    writeen  <= 1'b1;
                    tlast    <= (idx == LAST_IDX);
                    if (idx == LAST_IDX) begin
                        state <= RUN;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Bench for fir_coef_loader: scoreboard of expected coefficient streams
// checked by a monitor, plus per-scenario checks of busy/done/x_out timing.
module tb_fir_coef_loader;

    localparam int NTAPS = 7;
    localparam int CW    = 8;
    localparam int DW    = 8;
    localparam int AW    = 3;

    typedef struct {
        logic [CW-1:0] coef;
        logic          last;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [CW-1:0] cfg_data;
    logic          load_start;
    logic [DW-1:0] x_src;
    logic          x_src_valid;
    logic [CW-1:0] coef_val;
    logic          writeen;
    logic          tlast;
    logic [DW-1:0] x_out;
    logic          busy;
    logic          done;

    int n_vec = 0;
    int n_err = 0;
    exp_t exp_q[$];
    logic [CW-1:0] sb_bank [NTAPS];

    fir_coef_loader #(
        .NTAPS(NTAPS),
        .CW(CW),
        .DW(DW),
        .AW(AW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_we(cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_data(cfg_data),
        .load_start(load_start),
        .x_src(x_src),
        .x_src_valid(x_src_valid),
        .coef_val(coef_val),
        .writeen(writeen),
        .tlast(tlast),
        .x_out(x_out),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog time=%0t required finish before limit", $time);
        $fatal(1, "watchdog expired");
    end

    // Stream monitor: every writeen beat is matched against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (writeen === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL stream_extra coef_val=%0d tlast=%0b required no beat", coef_val, tlast);
            end else begin
                e = exp_q.pop_front();
                if (coef_val !== e.coef || tlast !== e.last) begin
                    n_err++;
                    $display("FAIL stream_beat coef_val=%0d tlast=%0b required coef_val=%0d tlast=%0b",
                             coef_val, tlast, e.coef, e.last);
                end
            end
        end else begin
            n_vec++;
            if (tlast !== 1'b0) begin
                n_err++;
                $display("FAIL tlast_idle tlast=%0b writeen=%0b required tlast=0", tlast, writeen);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input int a, input int d);
        cfg_we   = 1'b1;
        cfg_addr = AW'(a);
        cfg_data = CW'(d);
        tick();
        cfg_we = 1'b0;
        if (a < NTAPS) sb_bank[a] = CW'(d);
    endtask

    task automatic push_stream;
        for (int i = 0; i < NTAPS; i++) begin
            exp_q.push_back('{sb_bank[i], (i == NTAPS - 1)});
        end
    endtask

    task automatic test_reset;
        #2;
        n_vec++;
        if ({coef_val, writeen, tlast, x_out, busy, done} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got=%h required=0", {coef_val, writeen, tlast, x_out, busy, done});
        end
        #5 rst_n = 1'b1;
        tick();
        n_vec++;
        if ({coef_val, writeen, tlast, x_out, busy, done} !== '0) begin
            n_err++;
            $display("FAIL reset_release got=%h required=0", {coef_val, writeen, tlast, x_out, busy, done});
        end
    endtask

    task automatic test_gate_idle;
        x_src       = 8'd1;
        x_src_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (x_out !== '0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL gate_idle x_out=%0d busy=%0b required x_out=0 busy=0", x_out, busy);
            end
        end
        x_src       = '0;
        x_src_valid = 1'b0;
    endtask

    task automatic test_program_and_load;
        for (int i = 0; i < NTAPS; i++) write_cfg(i, (i + 1) * 10);
        push_stream();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || writeen !== 1'b0) begin
            n_err++;
            $display("FAIL load_latency busy=%0b writeen=%0b required 0 0", busy, writeen);
        end
        for (int i = 0; i < NTAPS; i++) begin
            tick();
            n_vec++;
            if (busy !== 1'b1 || writeen !== 1'b1 || done !== 1'b0) begin
                n_err++;
                $display("FAIL load_beat%0d busy=%0b writeen=%0b done=%0b required 1 1 0", i, busy, writeen, done);
            end
        end
        tick();
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0 || writeen !== 1'b0) begin
            n_err++;
            $display("FAIL done_pulse done=%0b busy=%0b writeen=%0b required 1 0 0", done, busy, writeen);
        end
    endtask

    task automatic test_sample_pass;
        x_src       = 8'd1;
        x_src_valid = 1'b1;
        tick();
        x_src = 8'd0;
        n_vec++;
        if (x_out !== 8'd1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL sample_one x_out=%0d done=%0b required x_out=1 done=0", x_out, done);
        end
        for (int i = 0; i < 19; i++) begin
            tick();
            n_vec++;
            if (x_out !== 8'd0) begin
                n_err++;
                $display("FAIL sample_zero%0d x_out=%0d required 0", i, x_out);
            end
        end
        x_src_valid = 1'b0;
    endtask

    task automatic test_write_during_load;
        push_stream();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < NTAPS; i++) begin
            cfg_we     = (i == 1);
            cfg_addr   = 3'd2;
            cfg_data   = 8'd99;
            load_start = (i == 1);
            tick();
            n_vec++;
            if (busy !== 1'b1) begin
                n_err++;
                $display("FAIL busy_hold%0d busy=%0b required 1", i, busy);
            end
        end
        cfg_we     = 1'b0;
        load_start = 1'b0;
        tick();
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL wdl_done done=%0b required 1", done);
        end
        // Back-to-back: request issued in the done cycle.
        push_stream();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        n_vec++;
        if (writeen !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_gap writeen=%0b busy=%0b required 0 0", writeen, busy);
        end
        for (int i = 0; i < NTAPS; i++) begin
            tick();
            n_vec++;
            if (busy !== 1'b1 || writeen !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_beat%0d busy=%0b writeen=%0b required 1 1", i, busy, writeen);
            end
        end
        tick();
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_done done=%0b required 1", done);
        end
    endtask

    task automatic test_addr_bounds;
        write_cfg(7, 55);
        cfg_we     = 1'b1;
        cfg_addr   = 3'd0;
        cfg_data   = 8'd5;
        load_start = 1'b1;
        sb_bank[0] = 8'd5;
        push_stream();
        tick();
        cfg_we     = 1'b0;
        load_start = 1'b0;
        for (int i = 0; i < NTAPS; i++) begin
            tick();
            n_vec++;
            if (busy !== 1'b1) begin
                n_err++;
                $display("FAIL bounds_beat%0d busy=%0b required 1", i, busy);
            end
        end
        tick();
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL bounds_done done=%0b required 1", done);
        end
    endtask

    task automatic test_reset_mid_load;
        push_stream();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (writeen !== 1'b1 || coef_val !== sb_bank[2]) begin
            n_err++;
            $display("FAIL mid_third writeen=%0b coef_val=%0d required 1 %0d", writeen, coef_val, sb_bank[2]);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({coef_val, writeen, tlast, x_out, busy, done} !== '0) begin
            n_err++;
            $display("FAIL mid_reset got=%h required=0", {coef_val, writeen, tlast, x_out, busy, done});
        end
        exp_q.delete();
        for (int i = 0; i < NTAPS; i++) sb_bank[i] = '0;
        #1 rst_n = 1'b1;
        tick();
        n_vec++;
        if (writeen !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_idle writeen=%0b busy=%0b required 0 0", writeen, busy);
        end
        push_stream();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        repeat (NTAPS) tick();
        tick();
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL zero_load_done done=%0b required 1", done);
        end
    endtask

    task automatic test_reprogram;
        for (int i = 0; i < NTAPS; i++) write_cfg(i, (i + 1) * 3);
        push_stream();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        repeat (NTAPS + 1) tick();
        x_src       = 8'h41;
        x_src_valid = 1'b1;
        tick();
        n_vec++;
        if (x_out !== 8'h41) begin
            n_err++;
            $display("FAIL run_sample x_out=%h required 41", x_out);
        end
        push_stream();
        load_start = 1'b1;
        x_src      = 8'h11;
        tick();
        load_start = 1'b0;
        n_vec++;
        if (x_out !== 8'h11) begin
            n_err++;
            $display("FAIL reprog_last_sample x_out=%h required 11", x_out);
        end
        for (int j = 0; j < NTAPS; j++) begin
            x_src = DW'(8'h20 + j);
            tick();
            n_vec++;
            if (x_out !== '0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL reprog_gate%0d x_out=%h busy=%0b required 0 1", j, x_out, busy);
            end
        end
        x_src = 8'h30;
        tick();
        n_vec++;
        if (x_out !== 8'h30 || done !== 1'b1) begin
            n_err++;
            $display("FAIL reprog_reopen x_out=%h done=%0b required 30 1", x_out, done);
        end
        x_src_valid = 1'b0;
        x_src       = '0;
    endtask

    initial begin
        rst_n       = 1'b0;
        cfg_we      = 1'b0;
        cfg_addr    = '0;
        cfg_data    = '0;
        load_start  = 1'b0;
        x_src       = '0;
        x_src_valid = 1'b0;
        for (int i = 0; i < NTAPS; i++) sb_bank[i] = '0;

        test_reset();
        test_gate_idle();
        test_program_and_load();
        test_sample_pass();
        test_write_during_load();
        test_addr_bounds();
        test_reset_mid_load();
        test_reprogram();

        tick();
        tick();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain pending=%0d required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
